// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads take absolute priority with a fixed
// three-cycle latency; two pixel writers share the remaining slots round-robin.
module vga_fb_arbiter #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          wr0_valid,
  output logic          wr0_ready,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  input  logic          wr1_valid,
  output logic          wr1_ready,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          cnt_clr,
  output logic [CW-1:0] wr0_cnt,
  output logic [CW-1:0] wr1_cnt,
  output logic [CW-1:0] stall_cnt
);

  typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_W0, GNT_W1} gnt_e;

  gnt_e          gnt_q, gnt_d;
  logic          rr_last_q, rr_last_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rd2_q, rd2_d;
  logic          disp_rvalid_q, disp_rvalid_d;
  logic [DW-1:0] disp_rdata_q, disp_rdata_d;
  logic [CW-1:0] wr0_cnt_q, wr0_cnt_d;
  logic [CW-1:0] wr1_cnt_q, wr1_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          acc0, acc1, stall;

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur,
                                             input logic ev, input logic clr_i);
    if (clr_i)
      return '0;
    if (ev && (cur != '1))
      return cur + CW'(1);
    return cur;
  endfunction

  always_comb begin
    gnt_d = GNT_NONE;
    if (disp_req)
      gnt_d = GNT_DISP;
    else if (wr0_valid && wr1_valid)
      gnt_d = rr_last_q ? GNT_W0 : GNT_W1;
    else if (wr0_valid)
      gnt_d = GNT_W0;
    else if (wr1_valid)
      gnt_d = GNT_W1;

    acc0  = wr0_valid && (gnt_d == GNT_W0);
    acc1  = wr1_valid && (gnt_d == GNT_W1);
    stall = (wr0_valid && !acc0) || (wr1_valid && !acc1);

    rr_last_d   = rr_last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (gnt_d)
      GNT_DISP: mem_addr_d = disp_addr;
      GNT_W0: begin
        mem_addr_d  = wr0_addr;
        mem_wdata_d = wr0_data;
        rr_last_d   = 1'b0;
      end
      GNT_W1: begin
        mem_addr_d  = wr1_addr;
        mem_wdata_d = wr1_data;
        rr_last_d   = 1'b1;
      end
      default: ;
    endcase

    // gnt_q == GNT_DISP marks the RAM command cycle; data returns one cycle later
    rd2_d         = (gnt_q == GNT_DISP);
    disp_rvalid_d = rd2_q;
    disp_rdata_d  = rd2_q ? mem_rdata : disp_rdata_q;

    wr0_cnt_d   = cnt_next(wr0_cnt_q, acc0, cnt_clr);
    wr1_cnt_d   = cnt_next(wr1_cnt_q, acc1, cnt_clr);
    stall_cnt_d = cnt_next(stall_cnt_q, stall, cnt_clr);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      gnt_q         <= GNT_NONE;
      rr_last_q     <= 1'b1;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd2_q         <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      wr0_cnt_q     <= '0;
      wr1_cnt_q     <= '0;
      stall_cnt_q   <= '0;
    end else begin
      gnt_q         <= gnt_d;
      rr_last_q     <= rr_last_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd2_q         <= rd2_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      wr0_cnt_q     <= wr0_cnt_d;
      wr1_cnt_q     <= wr1_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Readies are forced low while reset is asserted so no transfer is signalled
  assign wr0_ready   = acc0 && clr;
  assign wr1_ready   = acc1 && clr;
  assign mem_en      = (gnt_q != GNT_NONE);
  assign mem_we      = (gnt_q == GNT_W0) || (gnt_q == GNT_W1);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign wr0_cnt     = wr0_cnt_q;
  assign wr1_cnt     = wr1_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
